// File: rtl/mux_sched_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sched_ctrl_pkg
//  Description : Shared link-state encodings and default sizing for the
//                transaction-layer output mux and its scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_sched_ctrl_pkg;

    localparam int c_NUM_CH_DEF = 5;
    localparam int c_IDX_W_DEF  = 3;
    localparam int c_UMB_W_DEF  = 4;

    // One-hot link states; the mux decodes these same codes.
    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_sched_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin search. Starts one past the last
//                granted channel and wraps; masked channels are skipped.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CH = 5,
    parameter int IDX_W  = 3
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    input  logic [NUM_CH-1:0] i_mask,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_idx
);

    logic [NUM_CH-1:0] w_elig;
    logic [IDX_W-1:0]  w_cand;

    assign w_elig = i_req & ~i_mask;

    // Walk ptr+1 .. ptr+NUM_CH (mod NUM_CH); the first eligible channel wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int d = 1; d <= NUM_CH; d++) begin
            w_cand = IDX_W'((int'(i_ptr) + d) % NUM_CH);
            if (!o_valid && w_elig[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sched_ctrl
//  Description : Link state machine and round-robin scheduler for the
//                5-input transaction-layer output mux. Drives mux idx/req,
//                VC FIFO pops, and latches the flow-control threshold in INIT.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_sched_ctrl
    import mux_sched_ctrl_pkg::*;
#(
    parameter int NUM_CH = c_NUM_CH_DEF,
    parameter int IDX_W  = c_IDX_W_DEF,
    parameter int UMB_W  = c_UMB_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [UMB_W-1:0]  umbral_in,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic              dest_afull,
    output logic [3:0]        state,
    output logic [IDX_W-1:0]  idx,
    output logic              req,
    output logic [NUM_CH-1:0] pop,
    output logic [UMB_W-1:0]  umbral,
    output logic              idle_out
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_ptr;
    logic [NUM_CH-1:0] r_mask;
    logic [IDX_W-1:0]  r_idx;
    logic              r_req;
    logic [NUM_CH-1:0] r_pop;
    logic [UMB_W-1:0]  r_umbral;
    logic              r_idle;

    logic              w_arb_valid;
    logic [IDX_W-1:0]  w_arb_idx;
    logic              w_grant;
    logic [NUM_CH-1:0] w_grant_oh;
    logic              w_idle_nxt;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .i_req   (~fifo_empty),
        .i_ptr   (r_ptr),
        .i_mask  (r_mask),
        .o_valid (w_arb_valid),
        .o_idx   (w_arb_idx)
    );

    assign w_grant_oh = NUM_CH'(1) << w_arb_idx;
    // idle_out is aligned with the state it describes, so it looks at next state.
    assign w_idle_nxt = (w_state_nxt == ST_IDLE) && (&fifo_empty);

    // Next-state and grant decision; only IDLE without init/afull may grant.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT:   if (!init) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (init)            w_state_nxt = ST_INIT;
                else if (dest_afull) w_state_nxt = ST_ACTIVE;
                else                 w_grant     = w_arb_valid;
            end
            ST_ACTIVE: begin
                if (init)            w_state_nxt = ST_INIT;
                else if (!dest_afull) w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_RESET;
        endcase
    end

    // State, scheduler pointer/mask and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RESET;
            r_ptr    <= IDX_W'(NUM_CH - 1);
            r_mask   <= '0;
            r_idx    <= '0;
            r_req    <= 1'b0;
            r_pop    <= '0;
            r_umbral <= '0;
            r_idle   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_grant;
            r_pop   <= w_grant ? w_grant_oh : '0;
            r_idle  <= w_idle_nxt;
            if (w_grant) begin
                r_idx  <= w_arb_idx;
                r_ptr  <= w_arb_idx;
                // Block the just-popped channel for one cycle: its empty flag lags.
                r_mask <= w_grant_oh;
            end else begin
                r_mask <= '0;
            end
            if (r_state == ST_INIT) begin
                r_umbral <= umbral_in;
            end
        end
    end

    assign state    = r_state;
    assign idx      = r_idx;
    assign req      = r_req;
    assign pop      = r_pop;
    assign umbral   = r_umbral;
    assign idle_out = r_idle;

endmodule
`default_nettype wire
